reg_writeback_ctrl: RTL and testbench

Write-side initiator for the register file's single write port. Accepts results from the ALU and load paths over valid/ready and queues them in order in a small FIFO. Drains one entry per cycle onto the register file's mem_op/rd/write_data inputs, yielding the port to decode reads on request. Exports a pending-write mask for decode hazard checks.

---
 rtl/reg_writeback_ctrl_pkg.sv | 22 ++
 rtl/reg_writeback_ctrl_fifo.sv | 70 +++++++
 rtl/reg_writeback_ctrl.sv | 102 ++++++++++
 tb/tb_reg_writeback_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_writeback_ctrl_pkg.sv
// Shared types for the register-file write-back path.
// Provides the word / register-index types, the register file operation
// encoding, the queued write-back entry and the default queue depth.
package reg_writeback_ctrl_pkg;

    localparam int WB_WORD_SIZE  = 32;
    localparam int WB_FIFO_DEPTH = 4;

    typedef logic [WB_WORD_SIZE-1:0] word;
    typedef logic [4:0]              reg_index;

    typedef enum logic {
        READ_REG_DATA  = 1'b0,
        WRITE_REG_DATA = 1'b1
    } reg_file_op_t;

    typedef struct packed {
        reg_index rd;
        word      data;
    } wb_entry_t;

endpackage

// File: rtl/reg_writeback_ctrl_fifo.sv
// wb_fifo: dual-push, single-pop queue of write-back entries.
// Ports:
//   clock, reset_n           - clock and synchronous active-low reset
//   push0, push0_entry       - first push of the cycle (lands nearest the head)
//   push1, push1_entry       - second push of the cycle (lands behind push0)
//   pop                      - remove the head entry at this edge
//   head                     - entry at the read pointer
//   count                    - number of valid entries, 0..FIFO_DEPTH
//   entry_valid, entry_rd    - per-slot occupancy and destination register
// The caller guarantees pushes never exceed the free slots of the
// registered count; the storage itself is not reset.
module wb_fifo
    import reg_writeback_ctrl_pkg::*;
#(
    parameter  int FIFO_DEPTH = WB_FIFO_DEPTH,
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int CNT_W      = PTR_W + 1
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            push0,
    input  wb_entry_t                       push0_entry,
    input  logic                            push1,
    input  wb_entry_t                       push1_entry,
    input  logic                            pop,
    output wb_entry_t                       head,
    output logic [CNT_W-1:0]                count,
    output logic [FIFO_DEPTH-1:0]           entry_valid,
    output reg_index [FIFO_DEPTH-1:0]       entry_rd
);

    wb_entry_t        mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] wr_ptr1;
    logic [PTR_W-1:0] offset [FIFO_DEPTH];

    // push1 goes in the slot after push0 when both fire, else at wr_ptr.
    assign wr_ptr1 = wr_ptr + PTR_W'(push0);

    always_ff @(posedge clock) begin
        if (push0) mem[wr_ptr]  <= push0_entry;
        if (push1) mem[wr_ptr1] <= push1_entry;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PTR_W'(pop);
            wr_ptr <= wr_ptr + PTR_W'(push0) + PTR_W'(push1);
            count  <= count + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
        end
    end

    assign head = mem[rd_ptr];

    // A slot is occupied when its distance from the read pointer
    // (modulo the depth) is below the count.
    always_comb begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            offset[i]      = PTR_W'(i) - rd_ptr;
            entry_valid[i] = ({1'b0, offset[i]} < count);
            entry_rd[i]    = mem[i].rd;
        end
    end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// reg_writeback_ctrl: write-side initiator for the register file write port.
// Ports:
//   clock, reset_n                     - clock, synchronous active-low reset
//   alu_valid/alu_rd/alu_result/alu_ready      - ALU result handshake
//   load_valid/load_rd/load_data/load_ready    - load result handshake
//   read_req                           - decode claims the port this cycle
//   mem_op, rd, write_data             - register file write port drive
//   pending_mask                       - bit i set while a write to x_i is queued
//   port_busy                          - a write is being driven this cycle
// WORD_SIZE must match the package word width.
module reg_writeback_ctrl
    import reg_writeback_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH,
    parameter int WORD_SIZE  = WB_WORD_SIZE
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 alu_valid,
    input  reg_index             alu_rd,
    input  logic [WORD_SIZE-1:0] alu_result,
    output logic                 alu_ready,
    input  logic                 load_valid,
    input  reg_index             load_rd,
    input  logic [WORD_SIZE-1:0] load_data,
    output logic                 load_ready,
    input  logic                 read_req,
    output reg_file_op_t         mem_op,
    output reg_index             rd,
    output logic [WORD_SIZE-1:0] write_data,
    output logic [31:0]          pending_mask,
    output logic                 port_busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] ONE_FREE_MAX = CNT_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] TWO_FREE_MAX = CNT_W'(FIFO_DEPTH - 2);

    logic                     push0;
    logic                     push1;
    logic                     pop;
    wb_entry_t                push0_entry;
    wb_entry_t                push1_entry;
    wb_entry_t                head;
    logic [CNT_W-1:0]         count;
    logic [FIFO_DEPTH-1:0]    entry_valid;
    reg_index [FIFO_DEPTH-1:0] entry_rd;

    // Credit comes only from the registered count; a pop in the same
    // cycle does not free a slot early.
    assign load_ready = (count <= ONE_FREE_MAX);
    assign alu_ready  = load_valid ? (count <= TWO_FREE_MAX)
                                   : (count <= ONE_FREE_MAX);

    // Writes to x0 complete the handshake but are never queued.
    // The load is push0 so it is enqueued ahead of the ALU result.
    assign push0       = load_valid & load_ready & (load_rd != '0);
    assign push1       = alu_valid  & alu_ready  & (alu_rd  != '0);
    assign push0_entry = '{rd: load_rd, data: load_data};
    assign push1_entry = '{rd: alu_rd,  data: alu_result};

    // Gating with reset_n keeps a queued head from reaching the register
    // file on the edge that discards the queue.
    assign port_busy = reset_n & (count != '0) & ~read_req;
    assign pop       = port_busy;

    wb_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset_n     (reset_n),
        .push0       (push0),
        .push0_entry (push0_entry),
        .push1       (push1),
        .push1_entry (push1_entry),
        .pop         (pop),
        .head        (head),
        .count       (count),
        .entry_valid (entry_valid),
        .entry_rd    (entry_rd)
    );

    always_comb begin
        mem_op     = READ_REG_DATA;
        rd         = '0;
        write_data = '0;
        if (port_busy) begin
            mem_op     = WRITE_REG_DATA;
            rd         = head.rd;
            write_data = head.data;
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (entry_valid[i]) pending_mask[entry_rd[i]] = 1'b1;
        end
        pending_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
module tb_reg_writeback_ctrl;
    import reg_writeback_ctrl_pkg::*;

    localparam int DEPTH = 4;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         alu_valid, load_valid, read_req;
    logic [4:0]   alu_rd, load_rd;
    logic [31:0]  alu_result, load_data;
    logic         alu_ready, load_ready, port_busy;
    reg_file_op_t mem_op;
    logic [4:0]   rd;
    logic [31:0]  write_data, pending_mask;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    reg_writeback_ctrl #(.FIFO_DEPTH(DEPTH), .WORD_SIZE(32)) dut (
        .clock(clock), .reset_n(reset_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_result(alu_result), .alu_ready(alu_ready),
        .load_valid(load_valid), .load_rd(load_rd), .load_data(load_data), .load_ready(load_ready),
        .read_req(read_req), .mem_op(mem_op), .rd(rd), .write_data(write_data),
        .pending_mask(pending_mask), .port_busy(port_busy)
    );

    // Reference model: an ordered list of queued writes and a register file.
    typedef struct { logic [4:0] rd; logic [31:0] data; } ment_t;
    ment_t       mq[$];
    logic [31:0] mrf [32];
    logic [31:0] drf [32];

    function automatic int mfree();
        return DEPTH - mq.size();
    endfunction
    function automatic logic exp_load_ready();
        return mfree() >= 1;
    endfunction
    function automatic logic exp_alu_ready();
        return load_valid ? (mfree() >= 2) : (mfree() >= 1);
    endfunction
    function automatic logic exp_busy();
        return reset_n && (mq.size() > 0) && !read_req;
    endfunction
    function automatic logic [31:0] exp_mask();
        logic [31:0] m = '0;
        foreach (mq[i]) m[mq[i].rd] = 1'b1;
        return m;
    endfunction

    always @(posedge clock) begin : ref_model
        logic lr, ar, busy;
        if (!reset_n) begin
            mq.delete();
        end else begin
            lr   = exp_load_ready();
            ar   = exp_alu_ready();
            busy = exp_busy();
            if (busy) begin
                mrf[mq[0].rd] = mq[0].data;
                void'(mq.pop_front());
            end
            if (load_valid && lr && load_rd != 5'd0) mq.push_back('{load_rd, load_data});
            if (alu_valid && ar && alu_rd != 5'd0)   mq.push_back('{alu_rd, alu_result});
        end
    end

    // Register file sink driven by the DUT port.
    always @(posedge clock) begin
        if (mem_op == WRITE_REG_DATA) drf[rd] = write_data;
    end

    task automatic offer(input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                         input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic rr);
        load_valid = lv; load_rd = lrd; load_data  = ld;
        alu_valid  = av; alu_rd  = ard; alu_result = ad;
        read_req   = rr;
    endtask

    task automatic idle();
        offer(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        offer(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 1'b0);
        repeat (2) @(negedge clock);
        #1;
        n_checks++; if (mem_op !== READ_REG_DATA) $display("FAIL reset_mem_op got %0d want %0d", mem_op, READ_REG_DATA); else n_pass++;
        n_checks++; if (rd !== 5'd0) $display("FAIL reset_rd got %0d want 0", rd); else n_pass++;
        n_checks++; if (write_data !== 32'd0) $display("FAIL reset_wdata got %h want 0", write_data); else n_pass++;
        n_checks++; if (pending_mask !== 32'd0) $display("FAIL reset_mask got %h want 0", pending_mask); else n_pass++;
        n_checks++; if (port_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", port_busy); else n_pass++;
        n_checks++; if (dut.u_fifo.count !== 3'd0) $display("FAIL reset_count got %0d want 0", dut.u_fifo.count); else n_pass++;
        reset_n = 1'b1;
        idle();
        #1;
        n_checks++; if (load_ready !== 1'b1) $display("FAIL reset_load_ready got %b want 1", load_ready); else n_pass++;
        n_checks++; if (alu_ready !== 1'b1) $display("FAIL reset_alu_ready got %b want 1", alu_ready); else n_pass++;
        @(negedge clock);
    endtask

    task automatic test_single_write();
        offer(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
        #1;
        n_checks++; if (alu_ready !== 1'b1) $display("FAIL single_ready got %b want 1", alu_ready); else n_pass++;
        @(negedge clock);
        idle();
        #1;
        n_checks++; if (mem_op !== WRITE_REG_DATA) $display("FAIL single_op got %0d want %0d", mem_op, WRITE_REG_DATA); else n_pass++;
        n_checks++; if (rd !== 5'd5) $display("FAIL single_rd got %0d want 5", rd); else n_pass++;
        n_checks++; if (write_data !== 32'hDEADBEEF) $display("FAIL single_data got %h want deadbeef", write_data); else n_pass++;
        n_checks++; if (pending_mask !== 32'h20) $display("FAIL single_mask got %h want 20", pending_mask); else n_pass++;
        n_checks++; if (port_busy !== 1'b1) $display("FAIL single_busy got %b want 1", port_busy); else n_pass++;
        @(negedge clock);
        #1;
        n_checks++; if (pending_mask !== 32'h0) $display("FAIL single_mask_clr got %h want 0", pending_mask); else n_pass++;
        n_checks++; if (mem_op !== READ_REG_DATA) $display("FAIL single_op_idle got %0d want %0d", mem_op, READ_REG_DATA); else n_pass++;
        n_checks++; if (drf[5] !== 32'hDEADBEEF) $display("FAIL single_rf_x5 got %h want deadbeef", drf[5]); else n_pass++;
        @(negedge clock);
    endtask

    task automatic test_dual_push();
        offer(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0);
        #1;
        n_checks++; if ({load_ready, alu_ready} !== 2'b11) $display("FAIL dual_ready got %b want 11", {load_ready, alu_ready}); else n_pass++;
        @(negedge clock);
        idle();
        #1;
        n_checks++; if (rd !== 5'd3 || write_data !== 32'h11) $display("FAIL dual_first got x%0d=%h want x3=11", rd, write_data); else n_pass++;
        n_checks++; if (pending_mask !== 32'h18) $display("FAIL dual_mask1 got %h want 18", pending_mask); else n_pass++;
        @(negedge clock);
        #1;
        n_checks++; if (rd !== 5'd4 || write_data !== 32'h22) $display("FAIL dual_second got x%0d=%h want x4=22", rd, write_data); else n_pass++;
        n_checks++; if (pending_mask !== 32'h10) $display("FAIL dual_mask2 got %h want 10", pending_mask); else n_pass++;
        @(negedge clock);
        #1;
        n_checks++; if (pending_mask !== 32'h0 || port_busy !== 1'b0) $display("FAIL dual_done got mask %h busy %b want 0 0", pending_mask, port_busy); else n_pass++;
        n_checks++; if (drf[3] !== 32'h11 || drf[4] !== 32'h22) $display("FAIL dual_rf got %h %h want 11 22", drf[3], drf[4]); else n_pass++;
        @(negedge clock);
    endtask

    task automatic test_backpressure();
        offer(1'b1, 5'd8, 32'hA8, 1'b1, 5'd9, 32'hA9, 1'b1);
        #1;
        n_checks++; if ({load_ready, alu_ready} !== 2'b11) $display("FAIL bp_ready0 got %b want 11", {load_ready, alu_ready}); else n_pass++;
        n_checks++; if (mem_op !== READ_REG_DATA) $display("FAIL bp_op0 got %0d want %0d", mem_op, READ_REG_DATA); else n_pass++;
        @(negedge clock);
        offer(1'b1, 5'd10, 32'hAA, 1'b1, 5'd11, 32'hAB, 1'b1);
        #1;
        n_checks++; if ({load_ready, alu_ready} !== 2'b11) $display("FAIL bp_ready1 got %b want 11", {load_ready, alu_ready}); else n_pass++;
        n_checks++; if (mem_op !== READ_REG_DATA) $display("FAIL bp_op1 got %0d want %0d", mem_op, READ_REG_DATA); else n_pass++;
        @(negedge clock);
        offer(1'b1, 5'd12, 32'hAC, 1'b1, 5'd13, 32'hAD, 1'b1);
        #1;
        n_checks++; if ({load_ready, alu_ready} !== 2'b00) $display("FAIL bp_full_ready got %b want 00", {load_ready, alu_ready}); else n_pass++;
        n_checks++; if (mem_op !== READ_REG_DATA) $display("FAIL bp_op2 got %0d want %0d", mem_op, READ_REG_DATA); else n_pass++;
        n_checks++; if (dut.u_fifo.count !== 3'd4) $display("FAIL bp_count got %0d want 4", dut.u_fifo.count); else n_pass++;
        n_checks++; if (pending_mask !== 32'h0F00) $display("FAIL bp_mask got %h want 0f00", pending_mask); else n_pass++;
        @(negedge clock);
        idle();
        #1;
        n_checks++; if (load_ready !== 1'b0) $display("FAIL bp_no_pop_credit got %b want 0", load_ready); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (mem_op !== WRITE_REG_DATA || rd !== 5'(8 + k) || write_data !== 32'(32'hA8 + k))
                $display("FAIL bp_drain%0d got op %0d x%0d=%h want op 1 x%0d=%h", k, mem_op, rd, write_data, 8 + k, 32'hA8 + k);
            else n_pass++;
            @(negedge clock);
            #1;
        end
        n_checks++; if (port_busy !== 1'b0) $display("FAIL bp_empty_busy got %b want 0", port_busy); else n_pass++;
        n_checks++; if (drf[11] !== 32'hAB || drf[12] !== 32'h0) $display("FAIL bp_rf got x11=%h x12=%h want ab 0", drf[11], drf[12]); else n_pass++;
        @(negedge clock);
    endtask

    task automatic test_same_rd_x0();
        offer(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2, 1'b0);
        #1;
        n_checks++; if ({load_ready, alu_ready} !== 2'b11) $display("FAIL same_ready got %b want 11", {load_ready, alu_ready}); else n_pass++;
        @(negedge clock);
        idle();
        #1;
        n_checks++; if (rd !== 5'd7 || write_data !== 32'h1 || pending_mask !== 32'h80) $display("FAIL same_first got x%0d=%h mask %h want x7=1 mask 80", rd, write_data, pending_mask); else n_pass++;
        @(negedge clock);
        #1;
        n_checks++; if (rd !== 5'd7 || write_data !== 32'h2 || pending_mask !== 32'h80) $display("FAIL same_second got x%0d=%h mask %h want x7=2 mask 80", rd, write_data, pending_mask); else n_pass++;
        @(negedge clock);
        #1;
        n_checks++; if (pending_mask !== 32'h0 || drf[7] !== 32'h2) $display("FAIL same_final got mask %h x7=%h want 0 2", pending_mask, drf[7]); else n_pass++;
        offer(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF, 1'b0);
        #1;
        n_checks++; if (alu_ready !== 1'b1) $display("FAIL x0_ready got %b want 1", alu_ready); else n_pass++;
        @(negedge clock);
        idle();
        #1;
        n_checks++; if (port_busy !== 1'b0 || mem_op !== READ_REG_DATA || pending_mask !== 32'h0) $display("FAIL x0_dropped got busy %b op %0d mask %h want 0 0 0", port_busy, mem_op, pending_mask); else n_pass++;
        n_checks++; if (drf[0] !== 32'h0) $display("FAIL x0_rf got %h want 0", drf[0]); else n_pass++;
        @(negedge clock);
    endtask

    task automatic test_reset_mid_queue();
        offer(1'b1, 5'd14, 32'hE, 1'b1, 5'd15, 32'hF, 1'b1);
        @(negedge clock);
        offer(1'b0, 5'd0, 32'd0, 1'b1, 5'd16, 32'h10, 1'b1);
        @(negedge clock);
        offer(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
        #1;
        n_checks++; if (pending_mask !== 32'h1C000) $display("FAIL midrst_mask_before got %h want 1c000", pending_mask); else n_pass++;
        n_checks++; if (dut.u_fifo.count !== 3'd3) $display("FAIL midrst_count_before got %0d want 3", dut.u_fifo.count); else n_pass++;
        reset_n  = 1'b0;
        read_req = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        n_checks++; if (pending_mask !== 32'h0) $display("FAIL midrst_mask got %h want 0", pending_mask); else n_pass++;
        n_checks++; if (dut.u_fifo.count !== 3'd0) $display("FAIL midrst_count got %0d want 0", dut.u_fifo.count); else n_pass++;
        n_checks++; if (port_busy !== 1'b0 || mem_op !== READ_REG_DATA) $display("FAIL midrst_port got busy %b op %0d want 0 0", port_busy, mem_op); else n_pass++;
        @(negedge clock);
        #1;
        n_checks++; if (drf[14] !== 32'h0 || drf[15] !== 32'h0 || drf[16] !== 32'h0) $display("FAIL midrst_rf got %h %h %h want 0 0 0", drf[14], drf[15], drf[16]); else n_pass++;
        @(negedge clock);
    endtask

    task automatic test_random();
        logic        e_busy;
        logic [4:0]  e_rd;
        logic [31:0] e_wd;
        for (int c = 0; c < 300; c++) begin
            offer(1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), 32'($urandom),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), 32'($urandom),
                  $urandom_range(0, 3) == 0);
            #1;
            e_busy = exp_busy();
            e_rd   = e_busy ? mq[0].rd   : 5'd0;
            e_wd   = e_busy ? mq[0].data : 32'd0;
            n_checks++; if (load_ready !== exp_load_ready()) $display("FAIL rnd%0d_load_ready got %b want %b", c, load_ready, exp_load_ready()); else n_pass++;
            n_checks++; if (alu_ready !== exp_alu_ready()) $display("FAIL rnd%0d_alu_ready got %b want %b", c, alu_ready, exp_alu_ready()); else n_pass++;
            n_checks++; if (port_busy !== e_busy) $display("FAIL rnd%0d_busy got %b want %b", c, port_busy, e_busy); else n_pass++;
            n_checks++; if (mem_op !== (e_busy ? WRITE_REG_DATA : READ_REG_DATA)) $display("FAIL rnd%0d_op got %0d want %0d", c, mem_op, e_busy); else n_pass++;
            n_checks++; if (rd !== e_rd || write_data !== e_wd) $display("FAIL rnd%0d_port got x%0d=%h want x%0d=%h", c, rd, write_data, e_rd, e_wd); else n_pass++;
            n_checks++; if (pending_mask !== exp_mask()) $display("FAIL rnd%0d_mask got %h want %h", c, pending_mask, exp_mask()); else n_pass++;
            @(negedge clock);
        end
        idle();
        repeat (DEPTH + 2) @(negedge clock);
        #1;
        for (int r = 0; r < 32; r++) begin
            n_checks++; if (drf[r] !== mrf[r]) $display("FAIL rnd_rf_x%0d got %h want %h", r, drf[r], mrf[r]); else n_pass++;
        end
        @(negedge clock);
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin
            mrf[r] = 32'd0;
            drf[r] = 32'd0;
        end
        test_reset();
        test_single_write();
        test_dual_push();
        test_backpressure();
        test_same_rd_x0();
        test_reset_mid_queue();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
